// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared constants and types for the SRAM-backed FIFO controller
package sram_fifo_pkg;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 2 ** AW;

  // Total occupancy: SRAM contents plus in-flight read plus output buffer (0..DEPTH+2)
  typedef logic [AW+1:0] occ_t;

  // SRAM word pointer, wraps naturally at DEPTH
  typedef logic [AW-1:0] ptr_t;

endpackage

// File: rtl/sram_fifo_obuf.sv
// rtl/sram_fifo_obuf.sv - 2-entry registered output buffer that hides the SRAM read latency
module sram_fifo_obuf #(
  parameter int DW = sram_fifo_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic          valid,
  output logic [DW-1:0] head
);

  logic [DW-1:0] ent0;
  logic [DW-1:0] ent1;
  logic          do_pop;

  assign do_pop = pop && (occ != 2'd0);

  // ent0 is always the head; a simultaneous pop and push keeps arrival order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = ent0;
  assign valid = (occ != 2'd0);

endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller over a 512x16 single-port SRAM; optional SRAM_FIFO_BYPASS_EN
module sram_fifo_ctrl #(
  parameter int DW = sram_fifo_pkg::DW,
  parameter int AW = sram_fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          sram_me,
  output logic          sram_we,
  output logic [AW-1:0] sram_adr,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic [AW+1:0] count,
  output logic          full,
  output logic          empty
);

  import sram_fifo_pkg::*;

  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  logic [AW:0]   sram_cnt;
  logic          rd_pend;
  logic [1:0]    buf_occ;

  logic          rd_issue;
  logic          wr_fire;
  logic          wr_to_sram;
  logic          bypass_fire;
  logic          buf_push;
  logic [DW-1:0] buf_push_data;
  logic          buf_pop;

  assign full = (sram_cnt == (AW+1)'(DEPTH));

  // Prefetch decision uses registered state only, so out_ready never reaches the SRAM port
  assign rd_issue = (sram_cnt != '0) &&
                    (({1'b0, buf_occ} + {2'b00, rd_pend}) < 3'd2);

  assign in_ready = rst_n && !full && !rd_issue;
  assign wr_fire  = in_valid && in_ready;

`ifdef SRAM_FIFO_BYPASS_EN
  // Nothing older is stored or in flight, so the word may go straight to the buffer
  assign bypass_fire = wr_fire && (sram_cnt == '0) && !rd_pend && (buf_occ != 2'd2);
`else
  assign bypass_fire = 1'b0;
`endif

  assign wr_to_sram = wr_fire && !bypass_fire;

  // Read wins the single port; idle cycles leave the address parked on wr_ptr
  assign sram_me  = rd_issue || wr_to_sram;
  assign sram_we  = wr_to_sram;
  assign sram_adr = rd_issue ? rd_ptr : wr_ptr;
  assign sram_d   = in_data;

  // A pending read and a bypass write are mutually exclusive, so one push source per cycle
  assign buf_push      = rd_pend || bypass_fire;
  assign buf_push_data = rd_pend ? sram_q : in_data;
  assign buf_pop       = out_valid && out_ready;

  // Pointers, SRAM occupancy and the one-deep read-in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      if (rd_issue)   rd_ptr <= rd_ptr + ptr_t'(1);
      if (wr_to_sram) wr_ptr <= wr_ptr + ptr_t'(1);
      case ({wr_to_sram, rd_issue})
        2'b10:   sram_cnt <= sram_cnt + (AW+1)'(1);
        2'b01:   sram_cnt <= sram_cnt - (AW+1)'(1);
        default: ;
      endcase
      rd_pend <= rd_issue;
    end
  end

  sram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .occ       (buf_occ),
    .valid     (out_valid),
    .head      (out_data)
  );

  assign count = occ_t'(sram_cnt) + occ_t'(rd_pend) + occ_t'(buf_occ);
  assign empty = (count == '0);

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
FIFO controller that uses one external 512x16 single-port SRAM (1-cycle registered read, read-before-write on the same address) as its storage. It takes a valid/ready write stream, shares the single SRAM port between writes and prefetch reads, and hides the read latency behind a 2-entry output buffer so that it presents a valid/ready read stream. It sits directly upstream of the SRAM macro and drives all of its ports.

Parameters:
DW, 16, data width; must match SRAM D/Q width.
AW, 9, SRAM address width; DEPTH = 2**AW (512), localparam, not overridable.

Ports:
clk  in  1  clock; all state on posedge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  write-side data valid.
in_ready  out  1  write-side ready; transfer when in_valid&&in_ready at posedge.
in_data  in  DW  write data.
out_valid  out  1  read-side data valid (registered).
out_ready  in  1  read-side consumer ready; pop when out_valid&&out_ready.
out_data  out  DW  head-of-FIFO data (registered).
sram_me  out  1  SRAM memory enable (combinational).
sram_we  out  1  SRAM write enable (combinational).
sram_adr  out  AW  SRAM address (combinational).
sram_d  out  DW  SRAM write data (= in_data).
sram_q  in  DW  SRAM read data, valid the cycle after a read is issued.
count  out  AW+2  total occupancy = sram_cnt + rd_pend + buf_occ, 0..DEPTH+2.
full  out  1  sram_cnt == DEPTH.
empty  out  1  count == 0.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous assert, active-low, synchronous deassert at the system level.
- State: wr_ptr, rd_ptr (AW bits, natural wrap 511->0), sram_cnt (0..DEPTH), rd_pend (1 bit), buf_occ (0..2), 2-entry output buffer.
- Reset values: out_valid=0, out_data=0, count=0, empty=1, full=0, all pointers/counters 0, rd_pend=0. in_ready=0 and sram_me=0 while rst_n is low.
- rd_issue = (sram_cnt!=0) && (buf_occ + rd_pend < 2), computed only from registered state; it has no path from out_ready.
- Port arbitration: read has priority. If rd_issue: sram_me=1, sram_we=0, sram_adr=rd_ptr; at the edge, rd_ptr++, sram_cnt--, rd_pend=1.
- in_ready = rst_n && !full && !rd_issue. On a write transfer: sram_me=1, sram_we=1, sram_adr=wr_ptr; at the edge, wr_ptr++, sram_cnt++.
- Idle cycle: sram_me=0, sram_we=0; sram_adr and sram_d are don't-care but held stable.
- If rd_pend is set at an edge, sram_q is captured into the output buffer tail (buf_occ++) and rd_pend clears, unless a new read was issued in the same cycle.
- A pop and a capture in the same cycle preserve order: the head advances and the new word lands behind any remaining entry. buf_occ never exceeds 2 by construction.
- out_data is always the buffer head. out_valid = buf_occ!=0.
- Latency without bypass: a word accepted at edge T0 is read at T1, captured at T2, and out_valid is high in the cycle after T2.
- Full: sram_cnt==DEPTH forces in_ready=0. Reads still proceed and free space.
- Empty: with sram_cnt==0, no read is issued.
- Reset mid-operation: an in-flight read is discarded, buffered data is lost, and all state returns to reset values.

Optional Feature:
SRAM_FIFO_BYPASS_EN: when defined, a write accepted while sram_cnt==0 && rd_pend==0 && buf_occ<2 skips the SRAM. It goes straight into the output buffer (sram_me=0 that cycle), and out_valid is high in the cycle after acceptance. When undefined, every word goes through the SRAM with the latency given above.

Decomposition:
- Package sram_fifo_pkg: DW, AW, DEPTH constants; occupancy typedef (AW+2 bits); pointer typedef (AW bits).
- One sub-module, sram_fifo_obuf: the 2-entry output buffer with push (capture), pop, occupancy, head data and valid.

Test Plan:
1. Reset, then write 0x1234 with out_ready=1: sram_we pulse at adr 0, then read at adr 0, then out_data=0x1234 and out_valid high 2 edges after acceptance; count returns to 0.
2. out_ready=0, burst-write 514 words 0x0000..0x0201: buffer holds 2 words, SRAM fills to 512, full=1, in_ready=0, count=514. Then drain: data comes out in order with no loss.
3. Keep the SRAM at 511 entries while alternating push and pop across 1000 words: pointers wrap 511->0 and the output sequence matches the input sequence.
4. Continuous in_valid plus out_ready=1: reads win arbitration and in_ready deasserts exactly on rd_issue cycles. No deadlock occurs and order is preserved.
5. Assert rst_n low with rd_pend=1 and buf_occ=2: out_valid=0 and count=0 immediately (async). After release, the first new word 0xBEEF is read back correctly.
6. With SRAM_FIFO_BYPASS_EN and an empty FIFO, write 0xA5A5: sram_me stays 0 and out_valid is high the next cycle.
